// File: rtl/vga_timing_gen_if.sv
// Pixel-source bus: coordinate requests out to the source, pixel data back.
// The master (timing generator) drives requests; the slave (pixel source) returns data.
interface vga_timing_gen_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 12
) ();
  logic              pix_req;
  logic [CNT_W-1:0]  pix_x;
  logic [CNT_W-1:0]  pix_y;
  logic [DATA_W-1:0] pix_data;

  modport master (output pix_req, output pix_x, output pix_y, input  pix_data);
  modport slave  (input  pix_req, input  pix_x, input  pix_y, output pix_data);
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with prefetched pixel requests.
// Define VGA_BORDER_EN to drive border_color on the border band around the active area.
module vga_timing_gen #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 40,
  parameter int unsigned H_LEFT   = 8,
  parameter int unsigned H_VALID  = 640,
  parameter int unsigned H_RIGHT  = 8,
  parameter int unsigned H_FRONT  = 8,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 25,
  parameter int unsigned V_TOP    = 8,
  parameter int unsigned V_VALID  = 480,
  parameter int unsigned V_BOTTOM = 8,
  parameter int unsigned V_FRONT  = 2,
  parameter bit          H_POL    = 1'b1,
  parameter bit          V_POL    = 1'b1,
  parameter int unsigned REQ_LAT  = 1
) (
  input  logic              vga_clk,
  input  logic              rst,
  vga_timing_gen_if.master  pix_if,
  input  logic [DATA_W-1:0] border_color,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [DATA_W-1:0] rgb,
  output logic              frame_start,
  output logic              line_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int unsigned HA      = H_SYNC + H_BACK + H_LEFT;
  localparam int unsigned VA      = V_SYNC + V_BACK + V_TOP;

  if (longint'(H_TOTAL) > (longint'(1) << CNT_W)) begin : g_chk_h
    $error("CNT_W too narrow for H_TOTAL-1");
  end
  if (longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_chk_v
    $error("CNT_W too narrow for V_TOTAL-1");
  end
  if (REQ_LAT > 4) begin : g_chk_lat
    $error("REQ_LAT must be 0..4");
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
`ifdef VGA_BORDER_EN
    logic brd;
`endif
    logic fs;
    logic ls;
  } flags_t;

  logic [CNT_W-1:0]  cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
  int unsigned       h_pos, v_pos;
  logic              h_act, v_act, h_win, v_win;
  flags_t            flags_d;
  flags_t            dly_q [REQ_LAT+1];
  flags_t            last;
  logic              pix_req_q;
  logic [CNT_W-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic              hsync_q, vsync_q, de_q, fs_q, ls_q;
  logic [DATA_W-1:0] rgb_q, rgb_d;

  always_comb begin
    cnt_h_d = cnt_h_q + CNT_W'(1);
    cnt_v_d = cnt_v_q;
    if (cnt_h_q == CNT_W'(H_TOTAL - 1)) begin
      cnt_h_d = '0;
      cnt_v_d = (cnt_v_q == CNT_W'(V_TOTAL - 1)) ? '0 : cnt_v_q + CNT_W'(1);
    end
  end

  assign h_pos = 32'(cnt_h_q);
  assign v_pos = 32'(cnt_v_q);
  assign h_act = (h_pos >= HA) && (h_pos < HA + H_VALID);
  assign v_act = (v_pos >= VA) && (v_pos < VA + V_VALID);
  assign h_win = (h_pos >= HA - H_LEFT) && (h_pos < HA + H_VALID + H_RIGHT);
  assign v_win = (v_pos >= VA - V_TOP) && (v_pos < VA + V_VALID + V_BOTTOM);

  always_comb begin
    flags_d     = '0;
    flags_d.hs  = h_pos < H_SYNC;
    flags_d.vs  = v_pos < V_SYNC;
    flags_d.act = h_act && v_act;
`ifdef VGA_BORDER_EN
    flags_d.brd = h_win && v_win && !(h_act && v_act);
`endif
    flags_d.fs  = (h_pos == HA) && (v_pos == VA);
    flags_d.ls  = (h_pos == HA) && v_act;
    pix_x_d     = flags_d.act ? CNT_W'(h_pos - HA) : '1;
    pix_y_d     = flags_d.act ? CNT_W'(v_pos - VA) : '1;
  end

  // Counters, request stage and flag delay line share one reset domain.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      cnt_h_q   <= '0;
      cnt_v_q   <= '0;
      pix_req_q <= 1'b0;
      pix_x_q   <= '1;
      pix_y_q   <= '1;
      for (int unsigned i = 0; i <= REQ_LAT; i++) dly_q[i] <= '0;
    end else begin
      cnt_h_q   <= cnt_h_d;
      cnt_v_q   <= cnt_v_d;
      pix_req_q <= flags_d.act;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      dly_q[0]  <= flags_d;
      for (int unsigned i = 1; i <= REQ_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign pix_if.pix_req = pix_req_q;
  assign pix_if.pix_x   = pix_x_q;
  assign pix_if.pix_y   = pix_y_q;

  // The last delay stage lines up with pix_data for the same position.
  assign last = dly_q[REQ_LAT];

  always_comb begin
    rgb_d = '0;
    if (last.act) begin
      rgb_d = pix_if.pix_data;
`ifdef VGA_BORDER_EN
    end else if (last.brd) begin
      rgb_d = border_color;
`endif
    end
  end

`ifndef VGA_BORDER_EN
  logic unused_border;
  assign unused_border = ^{border_color, h_win, v_win};
`endif

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      hsync_q <= last.hs ? H_POL : ~H_POL;
      vsync_q <= last.vs ? V_POL : ~V_POL;
      de_q    <= last.act;
      rgb_q   <= rgb_d;
      fs_q    <= last.fs;
      ls_q    <= last.ls;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster with a random-content pixel source.
// Expected border behaviour follows VGA_BORDER_EN.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int HS = 4, HB = 3, HL = 2, HV = 16, HR = 2, HF = 3;
  localparam int VS = 2, VB = 2, VT = 1, VV = 6,  VBO = 1, VF = 2;
  localparam bit H_POL   = 1'b0;
  localparam bit V_POL   = 1'b1;
  localparam int REQ_LAT = 3;
  localparam int HT    = HS + HB + HL + HV + HR + HF;
  localparam int VTOT  = VS + VB + VT + VV + VBO + VF;
  localparam int HA    = HS + HB + HL;
  localparam int VA    = VS + VB + VT;
  localparam int FRAME = HT * VTOT;
  localparam int LAT2  = REQ_LAT + 2;
`ifdef VGA_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  typedef struct packed {
    logic              hs;
    logic              vs;
    logic              de;
    logic [DATA_W-1:0] rgb;
    logic              fs;
    logic              ls;
  } out_t;

  typedef struct packed {
    logic             req;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } req_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] border_color = '0;
  logic              hsync, vsync, de, frame_start, line_start;
  logic [DATA_W-1:0] rgb;
  out_t              got_o;
  req_t              got_r;
  int                n_vec = 0;
  int                n_err = 0;

  logic [DATA_W-1:0] mem [VV][HV];
  logic [DATA_W-1:0] src_q [REQ_LAT];
  logic [DATA_W-1:0] src_now, junk_q;

  vga_timing_gen_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  vga_timing_gen #(
    .DATA_W(DATA_W), .CNT_W(CNT_W),
    .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV), .H_RIGHT(HR), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_TOP(VT), .V_VALID(VV), .V_BOTTOM(VBO), .V_FRONT(VF),
    .H_POL(H_POL), .V_POL(V_POL), .REQ_LAT(REQ_LAT)
  ) dut (
    .vga_clk     (clk),
    .rst         (rst),
    .pix_if      (bus),
    .border_color(border_color),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb         (rgb),
    .frame_start (frame_start),
    .line_start  (line_start)
  );

  always #5 clk = ~clk;

  assign got_o = {hsync, vsync, de, rgb, frame_start, line_start};
  assign got_r = {bus.pix_req, bus.pix_x, bus.pix_y};

  // Pixel source: answers a request REQ_LAT cycles later, random junk when idle.
  always_comb begin
    src_now = junk_q;
    if (bus.pix_req && int'(bus.pix_x) < HV && int'(bus.pix_y) < VV)
      src_now = mem[int'(bus.pix_y)][int'(bus.pix_x)];
  end

  always @(posedge clk) begin
    junk_q   <= DATA_W'($urandom);
    src_q[0] <= src_now;
    for (int i = 1; i < REQ_LAT; i++) src_q[i] <= src_q[i-1];
  end

  assign bus.pix_data = src_q[REQ_LAT-1];

  // Reference model; c counts cycles since the first cycle with counters at (0,0).
  function automatic out_t model_out(input int c);
    out_t o;
    int p, h, v;
    bit act, win;
    o = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0, rgb: '0, fs: 1'b0, ls: 1'b0};
    if (c < LAT2) return o;
    p   = (c - LAT2) % FRAME;
    h   = p % HT;
    v   = p / HT;
    act = (h >= HA) && (h < HA + HV) && (v >= VA) && (v < VA + VV);
    win = (h >= HS + HB) && (h < HA + HV + HR) && (v >= VS + VB) && (v < VA + VV + VBO);
    o.hs  = (h < HS) ? H_POL : ~H_POL;
    o.vs  = (v < VS) ? V_POL : ~V_POL;
    o.de  = act;
    o.rgb = act ? mem[v-VA][h-HA] : ((win && BORDER_EN) ? border_color : '0);
    o.fs  = (h == HA) && (v == VA);
    o.ls  = (h == HA) && act;
    return o;
  endfunction

  function automatic req_t model_req(input int c);
    req_t r;
    int p, h, v;
    r = '{req: 1'b0, x: '1, y: '1};
    if (c < 1) return r;
    p = (c - 1) % FRAME;
    h = p % HT;
    v = p / HT;
    if ((h >= HA) && (h < HA + HV) && (v >= VA) && (v < VA + VV))
      r = '{req: 1'b1, x: CNT_W'(h - HA), y: CNT_W'(v - VA)};
    return r;
  endfunction

  task automatic fill_mem();
    for (int y = 0; y < VV; y++)
      for (int x = 0; x < HV; x++) mem[y][x] = DATA_W'($urandom);
  endtask

  // Leaves the bench #1 into the first cycle after release (model cycle 0).
  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_t eo;
    req_t er;
    eo = model_out(0);
    er = model_req(0);
    rst = 1'b1;
    border_color = DATA_W'($urandom) | DATA_W'(1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (got_o !== eo) begin
        n_err++;
        $display("FAIL reset_out cyc=%0d got=%h exp=%h", i, got_o, eo);
      end
      n_vec++;
      if (got_r !== er) begin
        n_err++;
        $display("FAIL reset_req cyc=%0d got=%h exp=%h", i, got_r, er);
      end
    end
  endtask

  task automatic test_frames();
    out_t eo;
    req_t er;
    int n_req = 0, n_ls = 0, n_fs = 0, n_hs = 0, n_vs = 0;
    fill_mem();
    border_color = DATA_W'($urandom) | DATA_W'(1);
    apply_reset(2);
    for (int c = 0; c < 2 * FRAME + LAT2 + 3; c++) begin
      eo = model_out(c);
      er = model_req(c);
      n_vec++;
      if (got_o !== eo) begin
        n_err++;
        $display("FAIL frames_out c=%0d got=%h exp=%h", c, got_o, eo);
      end
      n_vec++;
      if (got_r !== er) begin
        n_err++;
        $display("FAIL frames_req c=%0d got=%h exp=%h", c, got_r, er);
      end
      if (c >= 1 && c <= FRAME && bus.pix_req === 1'b1) n_req++;
      if (c >= LAT2 && c < LAT2 + FRAME) begin
        if (line_start === 1'b1) n_ls++;
        if (frame_start === 1'b1) n_fs++;
        if (hsync === H_POL) n_hs++;
        if (vsync === V_POL) n_vs++;
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (n_req != HV * VV) begin
      n_err++;
      $display("FAIL req_count got=%0d exp=%0d", n_req, HV * VV);
    end
    n_vec++;
    if (n_ls != VV) begin
      n_err++;
      $display("FAIL line_start_count got=%0d exp=%0d", n_ls, VV);
    end
    n_vec++;
    if (n_fs != 1) begin
      n_err++;
      $display("FAIL frame_start_count got=%0d exp=1", n_fs);
    end
    n_vec++;
    if (n_hs != HS * VTOT) begin
      n_err++;
      $display("FAIL hsync_active_count got=%0d exp=%0d", n_hs, HS * VTOT);
    end
    n_vec++;
    if (n_vs != VS * HT) begin
      n_err++;
      $display("FAIL vsync_active_count got=%0d exp=%0d", n_vs, VS * HT);
    end
  endtask

  task automatic test_mid_reset();
    out_t eo;
    req_t er;
    int target, first_vs;
    fill_mem();
    apply_reset(1);
    target = LAT2 + (VA + 2) * HT + HA + 5 + int'($urandom_range(0, 6));
    for (int c = 0; c < target; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    eo = model_out(0);
    er = model_req(0);
    n_vec++;
    if (got_o !== eo) begin
      n_err++;
      $display("FAIL midreset_out got=%h exp=%h", got_o, eo);
    end
    n_vec++;
    if (got_r !== er) begin
      n_err++;
      $display("FAIL midreset_req got=%h exp=%h", got_r, er);
    end
    first_vs = -1;
    for (int c = 0; c < FRAME; c++) begin
      if (first_vs < 0 && vsync === V_POL) first_vs = c;
      eo = model_out(c);
      n_vec++;
      if (got_o !== eo) begin
        n_err++;
        $display("FAIL restart_out c=%0d got=%h exp=%h", c, got_o, eo);
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (first_vs != LAT2) begin
      n_err++;
      $display("FAIL restart_vsync_delay got=%0d exp=%0d", first_vs, LAT2);
    end
  endtask

  task automatic test_border();
    int n_brd = 0, n_stray = 0, n_de = 0, exp_brd;
    fill_mem();
    border_color = DATA_W'($urandom) | DATA_W'(1);
    exp_brd = BORDER_EN ? ((HL + HV + HR) * (VT + VV + VBO) - HV * VV) : 0;
    apply_reset(1);
    for (int c = 0; c < LAT2 + FRAME; c++) begin
      if (c >= LAT2) begin
        if (de === 1'b1) n_de++;
        else if (rgb === border_color) n_brd++;
        else if (rgb !== '0) n_stray++;
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (n_brd != exp_brd) begin
      n_err++;
      $display("FAIL border_count got=%0d exp=%0d", n_brd, exp_brd);
    end
    n_vec++;
    if (n_stray != 0) begin
      n_err++;
      $display("FAIL blank_nonzero got=%0d exp=0", n_stray);
    end
    n_vec++;
    if (n_de != HV * VV) begin
      n_err++;
      $display("FAIL de_count got=%0d exp=%0d", n_de, HV * VV);
    end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_frames();
    test_mid_reset();
    test_border();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
